bcd_counter_mod: RTL and testbench
==================================

Name: bcd_counter_mod

Overview:
Parametrised multi-digit BCD up/down counter with a programmable terminal count: the next generation of the fixed two-digit mod-60 BCD counter. It supports any digit count and any BCD terminal value, counts up or down, and provides synchronous clear, validated parallel load, carry/borrow-out and a load-error flag. It is intended for time-of-day, timer and display-counter chains, where cascaded instances connect cout to the next stage's cin.

Parameters:
DIGITS, 2, number of BCD digits; counter width W = 4*DIGITS; legal range 1..8.
MAX_BCD, 8'h59, terminal count as a BCD value of width W; every nibble must be 0..9 and the value must be non-zero; the counter modulus is MAX_BCD+1 (decimal).

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
clr  input  1  synchronous clear of the count to 0
load  input  1  parallel load strobe
data  input  W  BCD value to load
cin  input  1  count enable, one step per cycle
dir  input  1  count direction: 1 = up, 0 = down
qout  output  W  current BCD count (registered)
cout  output  1  carry/borrow out (combinational)
load_err  output  1  registered one-cycle pulse: a rejected load occurred

Behaviour:
- Reset: one clock; reset is synchronous and active-high. With rst=1 at a rising edge: qout=0, load_err=0. rst overrides every other input. cout is combinational and reads 0 while rst=1.
- Priority at each edge: rst > clr > load > cin. Lower-priority requests in the same cycle are dropped, not queued.
- clr=1: qout<=0. load_err<=0.
- load=1 (clr=0):
  - data is legal when every nibble is <=9 and data <= MAX_BCD (decimal compare).
  - Legal data: qout<=data, load_err<=0.
  - Illegal data: qout holds, load_err<=1 for exactly one cycle.
- cin=1 with load=0 and clr=0, dir=1 (up):
  - qout==MAX_BCD gives qout<=0.
  - Otherwise BCD increment: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
- cin=1 with load=0 and clr=0, dir=0 (down):
  - qout==0 gives qout<=MAX_BCD.
  - Otherwise BCD decrement: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
- cin=0 with no clr or load: qout holds.
- load_err returns to 0 on any cycle without a rejected load.
- cout = cin & ~rst & ~clr & ~load & (dir ? qout==MAX_BCD : qout==0). It is asserted in the same cycle as the wrap step, so a cascaded stage counts on the same edge.
- Latency: every qout change is visible one cycle after the qualifying edge. There is no pipelining.
- Digit values 10..15 and values above MAX_BCD are unreachable, because load is validated and reset/clear force 0. No recovery logic is required.
- Direction may change on any cycle. The step follows the dir value sampled at that edge.
- DIGITS=1 is legal; the count is then simply 0..MAX_BCD.

Test Plan:
1. DIGITS=2, MAX_BCD=8'h59: reset, cin=1 dir=1 for 60 cycles -> qout runs 00..59 then 00. cout=1 only in the cycle qout=59. No nibble ever exceeds 9 (e.g. 09->10, 49->50).
2. Same config: load data=8'h00, then cin=1 dir=0 -> qout 59, 58, ..., 50, 49. cout=1 only in the cycle qout=00.
3. Illegal loads: data=8'h60 -> qout unchanged, load_err=1 for one cycle. data=8'h3A -> same. data=8'h42 -> qout=42, load_err=0.
4. Priority: with qout=59, assert cin=1 dir=1 load=1 data=8'h17 -> qout=17, cout=0. Then clr=1 load=1 cin=1 together -> qout=00. Then rst=1 clr=0 load=1 -> qout=00, load_err=0.
5. Cascade: DIGITS=3, MAX_BCD=12'h999, two instances chained via cout->cin with dir=1 -> the low instance at 999 with cin=1 gives low=000 and high increments on the same edge. The pair reads 000999 -> 001000.
6. Reset mid-count: DIGITS=1, MAX_BCD=4'h5, count up to 3, assert rst for one cycle with cin=1 -> qout=0. Counting resumes 1, 2, ... on the following cycles.

Source files
------------

// File: rtl/bcd_counter_mod_if.sv
// Control and data bundle for one BCD counter stage.
// The master (a controller or the previous stage) drives the requests.
// The slave (the counter) returns its count, carry/borrow and load status.
interface bcd_counter_mod_if #(
  parameter int W = 8
);

  logic         clr;
  logic         load;
  logic [W-1:0] data;
  logic         cin;
  logic         dir;
  logic [W-1:0] qout;
  logic         cout;
  logic         load_err;

  modport master (
    output clr, load, data, cin, dir,
    input  qout, cout, load_err
  );

  modport slave (
    input  clr, load, data, cin, dir,
    output qout, cout, load_err
  );

endinterface

// File: rtl/bcd_counter_mod.sv
// Multi-digit BCD up/down counter with a programmable terminal count.
// The count wraps MAX_BCD -> 0 going up and 0 -> MAX_BCD going down.
// cout is raised combinationally in the cycle of the wrap step, so a
// following stage with cin tied to this cout steps on the same edge.
// Loads are range-checked. A rejected load keeps the count and pulses
// load_err for one cycle.
module bcd_counter_mod #(
  parameter int                  DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] MAX_BCD = 8'h59
) (
  input  logic             clk,
  input  logic             rst,
  bcd_counter_mod_if.slave bus
);

  localparam int W = 4 * DIGITS;

  // True when every nibble of v is a decimal digit (0..9).
  function automatic logic bcd_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Reject parameter sets the counter cannot represent.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_mod: DIGITS must be 1..8");
  end
  if (!bcd_ok(MAX_BCD) || MAX_BCD == '0) begin : g_bad_max
    $error("bcd_counter_mod: MAX_BCD must be a non-zero BCD value");
  end

  logic [W-1:0] q_r;
  logic         err_r;
  logic [W-1:0] q_next;
  logic         err_next;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         inc_carry;
  logic         dec_borrow;
  logic         at_max;
  logic         at_zero;
  logic         load_legal;

  assign at_max  = (q_r == MAX_BCD);
  assign at_zero = (q_r == '0);

  // When every nibble is a decimal digit, comparing the raw vectors gives
  // the same order as comparing the decimal values.
  assign load_legal = bcd_ok(bus.data) && (bus.data <= MAX_BCD);

  // Ripple a +1 through the digits: a 9 rolls to 0 and passes the carry on.
  // NOTE: every variable written here gets a value on every path, starting
  // with the defaults below; a path that skipped one would infer a latch.
  always_comb begin
    inc_val   = '0;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!inc_carry) begin
        inc_val[4*i +: 4] = q_r[4*i +: 4];
      end else if (q_r[4*i +: 4] == 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
      end else begin
        inc_val[4*i +: 4] = q_r[4*i +: 4] + 4'd1;
        inc_carry         = 1'b0;
      end
    end
  end

  // Ripple a -1 through the digits: a 0 rolls to 9 and passes the borrow on.
  always_comb begin
    dec_val    = '0;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dec_borrow) begin
        dec_val[4*i +: 4] = q_r[4*i +: 4];
      end else if (q_r[4*i +: 4] == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
      end else begin
        dec_val[4*i +: 4] = q_r[4*i +: 4] - 4'd1;
        dec_borrow        = 1'b0;
      end
    end
  end

  // Next count and error flag, with priority clr > load > cin.
  // The terminal-count wrap overrides the digit ripple. The ripple alone
  // would only wrap at the all-nines or all-zeros boundary.
  always_comb begin
    q_next   = q_r;
    err_next = 1'b0;
    if (bus.clr) begin
      q_next = '0;
    end else if (bus.load) begin
      if (load_legal) q_next   = bus.data;
      else            err_next = 1'b1;
    end else if (bus.cin) begin
      if (bus.dir) q_next = at_max  ? '0      : inc_val;
      else         q_next = at_zero ? MAX_BCD : dec_val;
    end
  end

  // State registers; reset takes priority over every request.
  // NOTE: non-blocking assignments here make all flops sample the values
  // from before the edge; blocking ones would make the result depend on
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next;
      err_r <= err_next;
    end
  end

  assign bus.qout     = q_r;
  assign bus.load_err = err_r;
  assign bus.cout     = bus.cin & ~rst & ~bus.clr & ~bus.load &
                        (bus.dir ? at_max : at_zero);

endmodule

// File: tb/tb_bcd_counter_mod.sv
// Self-checking bench for bcd_counter_mod.
// Instance a: 2 digits, modulus 60. It gets directed and random stimulus
// and is checked against an integer reference model.
// Instances lo/hi: 3 digits, modulus 1000, chained through cout -> cin.
// Instance s: 1 digit, modulus 6.
module tb_bcd_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_c, rst_s;

  bcd_counter_mod_if #(.W(8))  a_if ();
  bcd_counter_mod_if #(.W(12)) lo_if ();
  bcd_counter_mod_if #(.W(12)) hi_if ();
  bcd_counter_mod_if #(.W(4))  s_if ();

  bcd_counter_mod #(.DIGITS(2), .MAX_BCD(8'h59)) u_a (
    .clk(clk), .rst(rst_a), .bus(a_if)
  );
  bcd_counter_mod #(.DIGITS(3), .MAX_BCD(12'h999)) u_lo (
    .clk(clk), .rst(rst_c), .bus(lo_if)
  );
  bcd_counter_mod #(.DIGITS(3), .MAX_BCD(12'h999)) u_hi (
    .clk(clk), .rst(rst_c), .bus(hi_if)
  );
  bcd_counter_mod #(.DIGITS(1), .MAX_BCD(4'h5)) u_s (
    .clk(clk), .rst(rst_s), .bus(s_if)
  );

  assign hi_if.cin = lo_if.cout;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for instance a, kept as a plain integer.
  localparam int M_A = 59;
  int m_val = 0;
  bit m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int bcd2int(input logic [31:0] v, input int digits);
    int r;
    r = 0;
    for (int i = digits - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int n);
    logic [31:0] r;
    int          x;
    r = '0;
    x = n;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit nib_ok(input logic [31:0] v, input int digits);
    for (int i = 0; i < digits; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of instance a. Drive the inputs, check cout combinationally,
  // clock, then check the registered outputs against the model.
  task automatic cyc_a(input string tag, input logic r, input logic c,
                       input logic l, input logic [7:0] d,
                       input logic ci, input logic dr);
    logic exp_cout;
    rst_a = r; a_if.clr = c; a_if.load = l; a_if.data = d;
    a_if.cin = ci; a_if.dir = dr;
    #1;
    exp_cout = ci && !r && !c && !l && (dr ? (m_val == M_A) : (m_val == 0));
    check({tag, ".cout"}, a_if.cout, exp_cout);
    if (r || c) begin
      m_val = 0;
      m_err = 1'b0;
    end else if (l) begin
      if (nib_ok(d, 2) && bcd2int(d, 2) <= M_A) begin
        m_val = bcd2int(d, 2);
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (ci) m_val = dr ? (m_val + 1) % (M_A + 1) : (m_val + M_A) % (M_A + 1);
    end
    @(posedge clk);
    #1;
    check({tag, ".qout"}, a_if.qout, int2bcd(m_val));
    check({tag, ".load_err"}, a_if.load_err, m_err);
  endtask

  initial begin
    rst_a = 1'b1; rst_c = 1'b1; rst_s = 1'b1;
    a_if.clr = 0;  a_if.load = 0;  a_if.data = '0;  a_if.cin = 0;  a_if.dir = 1;
    lo_if.clr = 0; lo_if.load = 0; lo_if.data = '0; lo_if.cin = 0; lo_if.dir = 1;
    hi_if.clr = 0; hi_if.load = 0; hi_if.data = '0;                hi_if.dir = 1;
    s_if.clr = 0;  s_if.load = 0;  s_if.data = '0;  s_if.cin = 0;  s_if.dir = 1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state of instance a.
    cyc_a("reset", 1, 0, 0, 8'h00, 1, 1);
    check("reset.qout_lit", a_if.qout, 32'h00);

    // Count up through a full period: 00..59 then back to 00.
    for (int k = 0; k < 60; k++) cyc_a("up60", 0, 0, 0, 8'h00, 1, 1);
    check("up60.wrap_lit", a_if.qout, 32'h00);

    // Load 00 and count down: 59, 58, ... 49.
    cyc_a("ld00", 0, 0, 1, 8'h00, 0, 0);
    for (int k = 0; k < 11; k++) cyc_a("down", 0, 0, 0, 8'h00, 1, 0);
    check("down.lit", a_if.qout, 32'h49);

    // Illegal loads are rejected; a legal one is taken.
    cyc_a("ld60", 0, 0, 1, 8'h60, 0, 1);
    check("ld60.err_lit", a_if.load_err, 32'h1);
    cyc_a("ld3A", 0, 0, 1, 8'h3A, 0, 1);
    cyc_a("ld42", 0, 0, 1, 8'h42, 0, 1);
    check("ld42.lit", a_if.qout, 32'h42);
    cyc_a("ld60b", 0, 0, 1, 8'h60, 0, 1);
    cyc_a("idle", 0, 0, 0, 8'h00, 0, 1);
    check("idle.err_lit", a_if.load_err, 32'h0);

    // Priority: load beats cin at terminal count, clr beats load, rst beats all.
    cyc_a("ld59", 0, 0, 1, 8'h59, 0, 1);
    a_if.load = 1; a_if.data = 8'h17; a_if.cin = 1; a_if.dir = 1;
    #1;
    check("prio.cout_lit", a_if.cout, 32'h0);
    cyc_a("prio_ld", 0, 0, 1, 8'h17, 1, 1);
    check("prio_ld.lit", a_if.qout, 32'h17);
    cyc_a("prio_clr", 0, 1, 1, 8'h17, 1, 1);
    check("prio_clr.lit", a_if.qout, 32'h00);
    cyc_a("ld33", 0, 0, 1, 8'h33, 0, 1);
    cyc_a("prio_rst", 1, 0, 1, 8'hFF, 1, 1);
    check("prio_rst.lit", a_if.qout, 32'h00);

    // Random stimulus against the model.
    for (int k = 0; k < 400; k++) begin
      logic       r, c, l, ci, dr;
      logic [7:0] d;
      r  = ($urandom_range(31) == 0);
      c  = ($urandom_range(15) == 0);
      l  = ($urandom_range(7) == 0);
      ci = ($urandom_range(3) != 0);
      dr = 1'($urandom_range(1));
      if ($urandom_range(1) == 1) d = 8'(int2bcd($urandom_range(59)));
      else                        d = 8'($urandom());
      cyc_a("rand", r, c, l, d, ci, dr);
    end

    // Cascade: lo at 999 with cin=1 wraps to 000 and hi steps on the same edge.
    rst_c = 1'b0;
    lo_if.load = 1; lo_if.data = 12'h999;
    hi_if.load = 1; hi_if.data = 12'h000;
    @(posedge clk);
    #1;
    lo_if.load = 0; hi_if.load = 0; lo_if.cin = 1;
    check("casc.pre", {hi_if.qout, lo_if.qout}, 32'h000999);
    #1;
    check("casc.cout", lo_if.cout, 32'h1);
    @(posedge clk);
    #1;
    check("casc.step", {hi_if.qout, lo_if.qout}, 32'h001000);
    check("casc.cout_low", lo_if.cout, 32'h0);
    repeat (1000) @(posedge clk);
    #1;
    check("casc.run", {hi_if.qout, lo_if.qout}, 32'h002000);
    lo_if.cin = 0;

    // Single digit, modulus 6: reset mid-count, then resume and wrap.
    rst_s = 1'b0; s_if.cin = 1; s_if.dir = 1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("s.up", s_if.qout, 32'(k));
    end
    rst_s = 1'b1;
    #1;
    check("s.rst_cout", s_if.cout, 32'h0);
    @(posedge clk);
    #1;
    check("s.rst", s_if.qout, 32'h0);
    rst_s = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check("s.resume", s_if.qout, 32'(k));
    end
    check("s.cout_max", s_if.cout, 32'h1);
    @(posedge clk);
    #1;
    check("s.wrap", s_if.qout, 32'h0);
    s_if.dir = 0;
    #1;
    check("s.cout_zero", s_if.cout, 32'h1);
    @(posedge clk);
    #1;
    check("s.down_wrap", s_if.qout, 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
